axis_ingress: RTL and testbench

- AXI4-Stream ingress stage at the parser front end; the receive-side counterpart of the egress stage.
- Accepts the external slave stream and registers it through a 2-entry skid buffer, so the internal path gets full-throughput, timing-isolated data.
- Tags each beat with start-of-frame and beat index.
- Produces per-frame byte length, frame-done pulse and a running frame counter for the parser and statistics logic.

---
 rtl/axis_ingress.sv | 100 ++++++++++
 tb/tb_axis_ingress.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ingress.sv
// axis_ingress: AXI4-Stream ingress skid buffer that tags beats with sof/index and reports per-frame byte totals
module axis_ingress #(
  parameter int DATA_WIDTH = 64,
  parameter int BEAT_IDX_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   axis_tdata_out,
  output logic [DATA_WIDTH/8-1:0] axis_tkeep_out,
  output logic                    axis_tvalid_out,
  input  logic                    axis_tready_out,
  output logic                    axis_tlast_out,
  output logic                    axis_sof_out,
  output logic [BEAT_IDX_W-1:0]   axis_beat_idx_out,
  output logic [15:0]             frame_bytes_out,
  output logic                    frame_done_out,
  output logic [31:0]             frame_count_out
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = DATA_WIDTH + KW + 2 + BEAT_IDX_W;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]            state_q, state_d;
  logic                  rdy_q, rdy_d;
  logic [BW-1:0]         main_q, main_d, skid_q, skid_d, in_beat;
  logic                  open_q, open_d;
  logic [BEAT_IDX_W-1:0] cnt_q, cnt_d;
  logic [15:0]           acc_q, acc_d, bytes_q, bytes_d, pop;
  logic [16:0]           sum;
  logic                  done_q, done_d;
  logic [31:0]           fcnt_q, fcnt_d;
  logic                  accept, consume;
  // sideband tags ride in the same packed word as the data so both registers keep them aligned
  assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, ~open_q, cnt_q};
  assign {axis_tdata_out, axis_tkeep_out, axis_tlast_out, axis_sof_out, axis_beat_idx_out} = main_q;
  assign axis_tvalid_out = state_q != EMPTY;
  assign s_axis_tready   = rdy_q;
  assign frame_bytes_out = bytes_q;
  assign frame_done_out  = done_q;
  assign frame_count_out = fcnt_q;
  always_comb begin
    accept  = s_axis_tvalid & rdy_q;
    consume = (state_q != EMPTY) & axis_tready_out;
    pop = '0;
    for (int i = 0; i < KW; i++) pop = pop + 16'(s_axis_tkeep[i]);
    sum = {1'b0, open_q ? acc_q : 16'd0} + {1'b0, pop};
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (state_q == EMPTY) begin
      state_d = accept ? ONE : EMPTY;
      main_d  = accept ? in_beat : main_q;
    end else if (state_q == ONE) begin
      main_d  = (accept & consume) ? in_beat : main_q;
      skid_d  = (accept & ~consume) ? in_beat : skid_q;
      state_d = (accept & ~consume) ? FULL : (consume & ~accept) ? EMPTY : ONE;
    end else if (consume) begin
      state_d = ONE;
      main_d  = skid_q;
    end
    rdy_d   = state_d != FULL;
    done_d  = accept & s_axis_tlast;
    open_d  = accept ? ~s_axis_tlast : open_q;
    cnt_d   = !accept ? cnt_q : s_axis_tlast ? '0 : (&cnt_q) ? cnt_q : cnt_q + BEAT_IDX_W'(1);
    acc_d   = !accept ? acc_q : sum[16] ? 16'hFFFF : sum[15:0];
    bytes_d = done_d ? acc_d : bytes_q;
    fcnt_d  = done_d ? fcnt_q + 32'd1 : fcnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
      open_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bytes_q <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      open_q  <= open_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bytes_q <= bytes_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_axis_ingress.sv
// tb_axis_ingress: randomized scoreboard bench for axis_ingress with a frame-level reference model
module tb_axis_ingress;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] axis_tdata_out;
  logic [7:0]  axis_tkeep_out;
  logic        axis_tvalid_out;
  logic        axis_tready_out = 1'b0;
  logic        axis_tlast_out;
  logic        axis_sof_out;
  logic [7:0]  axis_beat_idx_out;
  logic [15:0] frame_bytes_out;
  logic        frame_done_out;
  logic [31:0] frame_count_out;

  axis_ingress dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .axis_tdata_out(axis_tdata_out), .axis_tkeep_out(axis_tkeep_out), .axis_tvalid_out(axis_tvalid_out),
    .axis_tready_out(axis_tready_out), .axis_tlast_out(axis_tlast_out), .axis_sof_out(axis_sof_out),
    .axis_beat_idx_out(axis_beat_idx_out), .frame_bytes_out(frame_bytes_out),
    .frame_done_out(frame_done_out), .frame_count_out(frame_count_out)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        s;
    logic [7:0]  i;
  } beat_t;
  typedef struct {
    logic [15:0] bytes;
    int unsigned cnt;
    int          cyc;
  } frm_t;

  beat_t       beat_q[$];
  frm_t        frm_q[$];
  int          tests = 0, errs = 0, cyc = 0, sent = 0;
  int          rdy_pct = 100, stall_lo = 0, stall_hi = 0;
  int          occ = 0, nbeats = 0, tot = 0;
  int unsigned fcount = 0;
  bit          m_open = 0, rst_prev = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    axis_tready_out = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 : ($urandom_range(99) < rdy_pct);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks beats held by the DUT and the open frame purely from handshakes
  always @(negedge clk) begin
    bit a, c;
    if (!rst_n) begin
      beat_q.delete();
      frm_q.delete();
      occ = 0; m_open = 0; nbeats = 0; tot = 0; fcount = 0; rst_prev = 1;
    end else begin
      chk("s_tready", 128'(s_axis_tready), 128'(!rst_prev && occ < 2));
      chk("tvalid_out", 128'(axis_tvalid_out), 128'(occ != 0));
      if (rst_prev) begin
        chk("reset_data", 128'(axis_tdata_out), 128'd0);
        chk("reset_side", {axis_tkeep_out, axis_tlast_out, axis_sof_out, axis_beat_idx_out,
                           frame_bytes_out, frame_done_out, frame_count_out}, 128'd0);
      end
      a = s_axis_tvalid && s_axis_tready;
      c = axis_tvalid_out && axis_tready_out;
      if (a) begin
        tot = (m_open ? tot : 0) + $countones(s_axis_tkeep);
        beat_q.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast, !m_open,
                           nbeats > 255 ? 8'd255 : 8'(nbeats)});
        if (s_axis_tlast) begin
          fcount++;
          frm_q.push_back('{tot > 65535 ? 16'hFFFF : 16'(tot), fcount, cyc + 1});
          m_open = 0;
          nbeats = 0;
        end else begin
          m_open = 1;
          nbeats++;
        end
      end
      occ += int'(a) - int'(c);
      rst_prev = 0;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard heads
  always @(negedge clk) begin
    beat_t e;
    frm_t  f;
    if (rst_n) begin
      if (axis_tvalid_out) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 128'(axis_tvalid_out), 128'd0);
        else begin
          e = beat_q[0];
          chk("beat", {axis_tdata_out, axis_tkeep_out, axis_tlast_out, axis_sof_out, axis_beat_idx_out},
              {e.d, e.k, e.l, e.s, e.i});
          if (axis_tready_out) void'(beat_q.pop_front());
        end
      end
      if (frame_done_out) begin
        if (frm_q.size() == 0) chk("done_unexpected", 128'(frame_done_out), 128'd0);
        else begin
          f = frm_q.pop_front();
          chk("frame_stats", {frame_bytes_out, frame_count_out, 32'(cyc)}, {f.bytes, f.cnt, 32'(f.cyc)});
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] k, input bit last, input int gap);
    bit ok;
    int t;
    while (gap > 0 && $urandom_range(99) < gap) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tdata = {$urandom, $urandom};
    s_axis_tkeep = k;
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    ok = 0;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk); #1;
      t++;
    end
    s_axis_tvalid = 1'b0;
    if (!ok) begin
      tests++;
      errs++;
      $display("FAIL accept_timeout: got no ready expected ready within 200 cycles");
    end
  endtask

  task automatic send_frame(input int n, input int kf, input int gap);
    for (int b = 0; b < n; b++) send_beat(kf < 0 ? 8'($urandom) : 8'(kf), b == n - 1, gap);
    sent++;
  endtask

  task automatic drain();
    rdy_pct = 100;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_in_reset", 128'(s_axis_tready), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_sample", 128'(s_axis_tready), 128'd0);
    @(negedge clk);
    chk("ready_after_reset", 128'(s_axis_tready), 128'd1);
    chk("count_after_reset", 128'(frame_count_out), 128'd0);
    @(posedge clk); #1;
    send_beat(8'hFF, 0, 0);
    send_beat(8'hFF, 0, 0);
    send_beat(8'h0F, 1, 0);
    sent++;
    drain();
    chk("three_beat_bytes", 128'(frame_bytes_out), 128'd20);
    chk("three_beat_count", 128'(frame_count_out), 128'd1);
    stall_lo = cyc + 3;
    stall_hi = cyc + 6;
    send_frame(8, 'hFF, 0);
    drain();
    chk("stall_count", 128'(frame_count_out), 128'd2);
    for (int i = 0; i < 10; i++) send_frame(1, 'h01, 0);
    drain();
    chk("single_beat_count", 128'(frame_count_out), 128'd12);
    chk("single_beat_bytes", 128'(frame_bytes_out), 128'd1);
    send_frame(300, 'hFF, 0);
    drain();
    chk("long_frame_bytes", 128'(frame_bytes_out), 128'd2400);
    send_beat(8'hFF, 0, 0);
    send_beat(8'hFF, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sent = 0;
    @(negedge clk);
    chk("midframe_reset_count", 128'(frame_count_out), 128'd0);
    chk("midframe_reset_done", 128'(frame_done_out), 128'd0);
    @(posedge clk); #1;
    send_frame(3, 'h3F, 0);
    drain();
    chk("post_reset_bytes", 128'(frame_bytes_out), 128'd18);
    rdy_pct = 70;
    for (int i = 0; i < 40; i++)
      send_frame($urandom_range(1, 6), ($urandom_range(3) == 0) ? 0 : -1, 30);
    drain();
    chk("beats_left", 128'(beat_q.size()), 128'd0);
    chk("frames_left", 128'(frm_q.size()), 128'd0);
    chk("final_count", 128'(frame_count_out), 128'(sent));
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
